prga: RTL

//  ARC4 pseudo-random generation and decrypt stage; runs after ksa has permuted the S-box.

---
 rtl/arc4_pkg.sv | 22 ++
 rtl/prga.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions used by both the key-scheduling (ksa) and the
// pseudo-random generation (prga) stages.
package arc4_pkg;

    localparam int BYTE_W     = 8;
    localparam int SBOX_DEPTH = 256;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [3:0] {
        PRGA_IDLE   = 4'd0,
        PRGA_LEN    = 4'd1,
        PRGA_LATCH  = 4'd2,
        PRGA_RD_I   = 4'd3,
        PRGA_RD_J   = 4'd4,
        PRGA_WR_I   = 4'd5,
        PRGA_WR_J   = 4'd6,
        PRGA_RD_PAD = 4'd7,
        PRGA_WR_PT  = 4'd8
    } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 keystream generator and decryptor: swaps S[i]/S[j] per byte and XORs
// the pad S[S[i]+S[j]] into a length-prefixed ciphertext message.
module prga
    import arc4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    output logic  rdy,
    output byte_t s_addr,
    input  byte_t s_rddata,
    output byte_t s_wrdata,
    output logic  s_wren,
    output byte_t ct_addr,
    input  byte_t ct_rddata,
    output byte_t pt_addr,
    output byte_t pt_wrdata,
    output logic  pt_wren
);

    prga_state_t state;
    prga_state_t state_nxt;

    byte_t i;
    byte_t j;
    byte_t k;
    byte_t len;
    byte_t s_i;
    byte_t s_j;
    byte_t ct_b;

    // Datapath registers load in the state whose read data they capture;
    // memory reads have one cycle of latency, so each capture lags its address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PRGA_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            s_i   <= '0;
            s_j   <= '0;
            ct_b  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                PRGA_IDLE: begin
                    if (en) begin
                        i <= '0;
                        j <= '0;
                        k <= 8'd1;
                    end
                end
                PRGA_LATCH: begin
                    len <= ct_rddata;
                    i   <= 8'd1;
                end
                PRGA_RD_J: begin
                    s_i <= s_rddata;
                    j   <= j + s_rddata;
                end
                PRGA_WR_I: begin
                    s_j <= s_rddata;
                end
                PRGA_WR_J: begin
                    ct_b <= ct_rddata;
                end
                PRGA_WR_PT: begin
                    i <= i + 8'd1;
                    // Holding k at the last index keeps it from wrapping onto PT[0].
                    if (k != len) begin
                        k <= k + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        case (state)
            PRGA_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_nxt = PRGA_LEN;
                end
            end
            PRGA_LEN: begin
                ct_addr   = '0;
                state_nxt = PRGA_LATCH;
            end
            PRGA_LATCH: begin
                pt_addr   = '0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                state_nxt = (ct_rddata == '0) ? PRGA_IDLE : PRGA_RD_I;
            end
            PRGA_RD_I: begin
                s_addr    = i;
                state_nxt = PRGA_RD_J;
            end
            PRGA_RD_J: begin
                s_addr    = j + s_rddata;
                state_nxt = PRGA_WR_I;
            end
            PRGA_WR_I: begin
                s_addr    = i;
                s_wrdata  = s_rddata;
                s_wren    = 1'b1;
                ct_addr   = k;
                state_nxt = PRGA_WR_J;
            end
            PRGA_WR_J: begin
                s_addr    = j;
                s_wrdata  = s_i;
                s_wren    = 1'b1;
                state_nxt = PRGA_RD_PAD;
            end
            // Issued after the WR_J edge, so the pad lookup sees the swapped S-box.
            PRGA_RD_PAD: begin
                s_addr    = s_i + s_j;
                state_nxt = PRGA_WR_PT;
            end
            PRGA_WR_PT: begin
                pt_addr   = k;
                pt_wrdata = s_rddata ^ ct_b;
                pt_wren   = 1'b1;
                state_nxt = (k == len) ? PRGA_IDLE : PRGA_RD_I;
            end
            default: begin
                state_nxt = PRGA_IDLE;
            end
        endcase
    end

endmodule
